// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: configurable width, parity and stop bits, 3-sample majority vote,
// false-start rejection, break detection and a valid/ready output register.
//   state     | meaning
//   IDLE      | waiting for a 1->0 edge on the synchronised line
//   START     | timing to the start-bit centre; a high vote is a false start
//   DATA      | voting and shifting in data bits, LSB first
//   PARITY    | voting the parity bit (only when PARITY != 0)
//   STOP      | voting stop bits; the last decision completes the frame
//   WAIT_HIGH | frame ended on a low stop bit; hold off until the line returns high
module uart_rx_frame #(
  parameter int CLOCK_MULTIPLE = 16,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 uart_clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_detect,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF = CLOCK_MULTIPLE / 2;
  localparam int TW   = $clog2(CLOCK_MULTIPLE);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q, sync_live;
  logic                   rxs, prev_hi;
  logic [1:0]             hist;
  logic [TW-1:0]          tick, tick_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_acc, any_one, stop_zero;
  logic                   decide, vote, done;
  logic                   fe_new, brk_new, pe_new;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign vote = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
  assign busy = (state != S_IDLE);
  assign decide = (tick == '0) &&
                  (state == S_START || state == S_DATA || state == S_PARITY || state == S_STOP);

  // sync_live marks when rxs reflects a real line sample rather than the reset value,
  // so a line held low through reset release is never taken as a start edge.
  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '1;
      sync_live <= '0;
      prev_hi   <= 1'b0;
      hist      <= 2'b11;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      sync_live <= {sync_live[SYNC_STAGES-2:0], 1'b1};
      prev_hi   <= rxs & sync_live[SYNC_STAGES-1];
      hist      <= {hist[0], rxs};
    end
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      tick  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = (tick != '0) ? tick - 1'b1 : tick;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (prev_hi && !rxs) begin
          state_nxt = S_START;
          tick_nxt  = TW'(HALF);
        end
      end
      S_START: begin
        if (decide) begin
          tick_nxt = TW'(CLOCK_MULTIPLE - 1);
          if (vote) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            cnt_nxt   = 4'(DATA_BITS - 1);
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          tick_nxt = TW'(CLOCK_MULTIPLE - 1);
          if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
          end else if (PARITY != 0) begin
            state_nxt = S_PARITY;
          end else begin
            state_nxt = S_STOP;
            cnt_nxt   = 4'(STOP_BITS - 1);
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          tick_nxt  = TW'(CLOCK_MULTIPLE - 1);
          state_nxt = S_STOP;
          cnt_nxt   = 4'(STOP_BITS - 1);
        end
      end
      S_STOP: begin
        if (decide) begin
          tick_nxt = TW'(CLOCK_MULTIPLE - 1);
          if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
          end else begin
            done      = 1'b1;
            state_nxt = vote ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // any_one tracks whether any bit after the start voted 1; none means a break.
  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      par_acc   <= 1'b0;
      any_one   <= 1'b0;
      stop_zero <= 1'b0;
    end else if (decide) begin
      case (state)
        S_START: begin
          par_acc   <= 1'b0;
          any_one   <= 1'b0;
          stop_zero <= 1'b0;
        end
        S_DATA: begin
          shreg   <= {vote, shreg[DATA_BITS-1:1]};
          par_acc <= par_acc ^ vote;
          any_one <= any_one | vote;
        end
        S_PARITY: begin
          par_acc <= par_acc ^ vote;
          any_one <= any_one | vote;
        end
        S_STOP: begin
          stop_zero <= stop_zero | ~vote;
          any_one   <= any_one | vote;
        end
        default: ;
      endcase
    end
  end

  assign fe_new  = stop_zero | ~vote;
  assign brk_new = ~(any_one | vote);
  assign pe_new  = (PARITY != 0) && !brk_new && (par_acc != (PARITY == 1));

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      data          <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (data_valid && !data_ready) begin
          overrun <= 1'b1;
        end else begin
          data          <= shreg;
          data_valid    <= 1'b1;
          parity_error  <= pe_new;
          framing_error <= fe_new;
          break_detect  <= brk_new;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised oversampling UART receiver, the successor to the fixed 8N1 receiver.
Supports configurable data width, parity and stop bits, with 3-sample majority voting, false-start rejection and break detection.
Per-frame error flags are presented alongside the data.
It sits between the pad-side serial line and a byte-stream consumer, and uses a valid/ready output handshake.

Parameters:
CLOCK_MULTIPLE, 16, uart_clk cycles per bit; even, >= 4.
DATA_BITS, 8, data bits per frame; 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 2, input synchroniser depth; >= 2.

Ports:
uart_clk  input  1  sole clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset.
uart_rx  input  1  asynchronous serial line; idles high.
data  output  DATA_BITS  received word, LSB received first.
data_valid  output  1  data and error flags are valid.
data_ready  input  1  consumer accepts the word when data_valid && data_ready.
parity_error  output  1  parity mismatch for the presented word; 0 when PARITY = 0.
framing_error  output  1  at least one stop bit sampled 0 for the presented word.
break_detect  output  1  presented word came from a break (all bits 0).
overrun  output  1  one-cycle pulse when a completed frame is dropped.
busy  output  1  receiver is not in IDLE.

Behaviour:
- Reset (reset = 0, asynchronous): synchroniser stages = 1, state = IDLE. Outputs: data = 0, data_valid = 0, all error flags = 0, overrun = 0, busy = 0.
- Line sampling: uart_rx passes through SYNC_STAGES flops. Call the synchroniser output rxs. All timing below is relative to rxs.
- Frame timing: H = CLOCK_MULTIPLE/2. Cycle 0 is the first cycle with rxs = 0 in IDLE.
  - Bit k (k = 0 is start) has its centre at cycle H + k*CLOCK_MULTIPLE.
  - The bit value is the majority of rxs at centre-1, centre and centre+1.
  - The bit is decided at centre+1.
- States:
  - IDLE: busy = 0. A start is accepted only on a 1 -> 0 transition of rxs. The line must have been high for at least 1 cycle since reset or since the previous frame ended.
  - START: if the start-bit vote = 1, this is a false start; return to IDLE, no output.
  - DATA: shift in DATA_BITS votes, LSB first.
  - PARITY: present only if PARITY != 0. parity_error = (XOR of data bits and parity bit) != (PARITY == 1 ? 1 : 0).
  - STOP: STOP_BITS votes. framing_error = any stop vote == 0.
  - WAIT_HIGH: entered after any frame whose last stop vote = 0. Stays until rxs = 1, then goes to IDLE.
- Completion: the cycle after the last stop-bit decision, the output register loads data and the flags, and data_valid goes to 1.
  - Example, 8N1 with CLOCK_MULTIPLE = 16: data_valid rises at cycle 154.
- Break: data bits, parity bit and stop bits all vote 0. Result: data = 0, framing_error = 1, break_detect = 1, parity_error = 0.
- Handshake:
  - data_valid is held, with data and flags stable, until the cycle data_valid && data_ready is sampled.
  - On that cycle data_valid clears at the next edge, unless a new frame completes on the same cycle, in which case data_valid stays 1 and the new word loads.
- Overrun: a frame completes while data_valid = 1 and data_ready = 0.
  - The new frame is discarded and the old word and flags are retained.
  - overrun pulses 1 for exactly 1 cycle.
- Reception continues during a stalled output; the frame FSM never waits on data_ready.
- Reset mid-frame: the frame is abandoned and no output is produced. If the line is held low through reset release, no start is accepted until rxs has been 1.

Test Plan:
1. 8N1, CLOCK_MULTIPLE = 16, send 0xA5, data_ready = 1 -> data = 0xA5, data_valid high for 1 cycle at rxs-cycle 154, all error flags 0.
2. PARITY = 2, send 0x03 with parity bit 1 (correct is 0) -> data = 0x03, parity_error = 1, framing_error = 0. Then send 0x07 with parity bit 1 -> parity_error = 0.
3. Glitch: uart_rx low for 4 cycles, then high -> no data_valid, busy returns to 0 after the start-bit vote. A following frame 0x3C is received correctly.
4. Send 0x55 with stop bit 0, then line high -> data = 0x55, framing_error = 1, break_detect = 0, passes through WAIT_HIGH. Single-cycle low spikes at bit centres are out-voted; an 0xF0 frame with such spikes receives 0xF0.
5. Break: line low for 20 bit times -> one word, data = 0x00, break_detect = 1, framing_error = 1. No second word until the line returns high and a new start arrives.
6. Backpressure: data_ready = 0, send 0x11 then 0x22 -> data stays 0x11, overrun pulses once at completion of 0x22. Assert reset mid-frame of 0x33 -> all outputs 0, no word.
